north_pattern_writer: RTL



---
 rtl/north_pattern_writer_if.sv | 38 +++
 rtl/north_pattern_writer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/north_pattern_writer_if.sv
// North pattern writer AXI4 write-channel bundle (512-bit data path).
// Only the fields the generator drives or observes are carried here.
// The fixed AXI fields (awburst, awsize, awcache, awprot, awlock, awqos,
// awregion) are tied off in the role wrapper.
//
// Signals:
//   awaddr/awlen/awvalid/awready : write address channel
//   wdata/wstrb/wlast/wvalid/wready : write data channel
//   bresp/bvalid/bready          : write response channel
// Modports:
//   master : the traffic generator
//   slave  : the static-region side, or a bench responder
interface north_pattern_writer_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [511:0]      wdata;
    logic [63:0]       wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/north_pattern_writer.sv
// North pattern writer: burst-write traffic generator for the NORTH role.
// It writes a deterministic 512-bit pattern over a host-programmed range
// using INCR bursts. Bursts never cross a 4 KB page, and at most one burst is
// outstanding. It reports completion and write-response errors.
//
// Parameters:
//   ADDR_W    : AXI address width
//   MAX_BURST : maximum beats per burst (1..256)
// Ports:
//   CLK_IN_250 : sole clock
//   AXI_RESET  : asynchronous, active-high reset
//   START      : one-cycle start pulse, sampled only when idle
//   BASE_ADDR  : start byte address, bits [5:0] treated as zero
//   NUM_BEATS  : total 64-byte beats to write
//   SEED       : pattern seed
//   BUSY       : high from accepted START until DONE
//   DONE       : one-cycle completion pulse
//   ERR        : sticky error flag, set by any non-OKAY bresp
//   ERR_CNT    : saturating count of non-OKAY bresp
//   M_AXI      : AXI4 write master (north_pattern_writer_if.master)
// Build option:
//   NORTH_PATTERN_WRITER_ERR_ABORT_EN : when defined, the first error
//   response ends the transfer and skips the remaining beats.
//
// state | meaning
// IDLE  | waiting for START
// AW    | presenting the burst address, awvalid high
// W     | streaming burst beats, wvalid high
// B     | waiting for the write response, bready high
// FIN   | raising the one-cycle DONE pulse
module north_pattern_writer #(
    parameter int ADDR_W    = 64,
    parameter int MAX_BURST = 64
) (
    input  logic                 CLK_IN_250,
    input  logic                 AXI_RESET,
    input  logic                 START,
    input  logic [ADDR_W-1:0]    BASE_ADDR,
    input  logic [31:0]          NUM_BEATS,
    input  logic [31:0]          SEED,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [15:0]          ERR_CNT,
    north_pattern_writer_if.master M_AXI
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       remaining_q;
    logic [27:0]       beat_idx;
    logic [31:0]       seed_q;
    logic [8:0]        len_q;
    logic [7:0]        wcnt;

    logic [ADDR_W-1:0] start_addr;
    logic [8:0]        start_len;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       next_rem;
    logic [8:0]        next_len;
    logic              bad_resp;
    logic              abort_now;

    // Burst length limited by what is left, the burst cap and the distance
    // to the next 4 KB page. Addresses are 64-byte aligned, so only the
    // line offset within the page matters.
    function automatic logic [8:0] burst_len(input logic [5:0]  page_off,
                                             input logic [31:0] rem);
        logic [8:0] len;
        logic [8:0] to_page;
        to_page = 9'd64 - {3'b000, page_off};
        len     = 9'(MAX_BURST);
        if (to_page < len) begin
            len = to_page;
        end
        if (rem < {23'd0, len}) begin
            len = rem[8:0];
        end
        return len;
    endfunction

    function automatic logic [511:0] pattern(input logic [31:0] seed,
                                             input logic [27:0] idx);
        logic [511:0] data;
        data = '0;
        for (int i = 0; i < 16; i++) begin
            data[i*32 +: 32] = seed ^ {idx, 4'(i)};
        end
        return data;
    endfunction

    assign start_addr = BASE_ADDR & ~ADDR_W'(64'h3f);
    assign start_len  = burst_len(start_addr[11:6], NUM_BEATS);
    assign next_addr  = addr_q + {{(ADDR_W-15){1'b0}}, len_q, 6'b000000};
    assign next_rem   = remaining_q - {23'd0, len_q};
    assign next_len   = burst_len(next_addr[11:6], next_rem);
    assign bad_resp   = (M_AXI.bresp != 2'b00);

`ifdef NORTH_PATTERN_WRITER_ERR_ABORT_EN
    assign abort_now = bad_resp;
`else
    assign abort_now = 1'b0;
`endif

    assign M_AXI.wstrb = '1;

    always_ff @(posedge CLK_IN_250 or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state          <= S_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            beat_idx       <= '0;
            seed_q         <= '0;
            len_q          <= '0;
            wcnt           <= '0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            ERR            <= 1'b0;
            ERR_CNT        <= '0;
            M_AXI.awaddr   <= '0;
            M_AXI.awlen    <= '0;
            M_AXI.awvalid  <= 1'b0;
            M_AXI.wdata    <= '0;
            M_AXI.wlast    <= 1'b0;
            M_AXI.wvalid   <= 1'b0;
            M_AXI.bready   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        BUSY     <= 1'b1;
                        ERR      <= 1'b0;
                        ERR_CNT  <= '0;
                        seed_q   <= SEED;
                        beat_idx <= '0;
                        if (NUM_BEATS == 32'd0) begin
                            state <= S_FIN;
                        end else begin
                            addr_q        <= start_addr;
                            remaining_q   <= NUM_BEATS;
                            len_q         <= start_len;
                            M_AXI.awaddr  <= start_addr;
                            M_AXI.awlen   <= 8'(start_len - 9'd1);
                            M_AXI.awvalid <= 1'b1;
                            state         <= S_AW;
                        end
                    end
                end

                S_AW: begin
                    if (M_AXI.awready) begin
                        M_AXI.awvalid <= 1'b0;
                        M_AXI.wvalid  <= 1'b1;
                        M_AXI.wdata   <= pattern(seed_q, beat_idx);
                        M_AXI.wlast   <= (len_q == 9'd1);
                        wcnt          <= '0;
                        state         <= S_W;
                    end
                end

                S_W: begin
                    if (M_AXI.wready) begin
                        beat_idx <= beat_idx + 28'd1;
                        if (M_AXI.wlast) begin
                            M_AXI.wvalid <= 1'b0;
                            M_AXI.wlast  <= 1'b0;
                            M_AXI.bready <= 1'b1;
                            state        <= S_B;
                        end else begin
                            wcnt        <= wcnt + 8'd1;
                            M_AXI.wdata <= pattern(seed_q, beat_idx + 28'd1);
                            // wcnt still holds the beat just accepted, so the
                            // following beat is the last when wcnt+2 == len.
                            M_AXI.wlast <= ({1'b0, wcnt} + 9'd2 == len_q);
                        end
                    end
                end

                S_B: begin
                    if (M_AXI.bvalid) begin
                        M_AXI.bready <= 1'b0;
                        if (bad_resp) begin
                            ERR <= 1'b1;
                            if (ERR_CNT != 16'hffff) begin
                                ERR_CNT <= ERR_CNT + 16'd1;
                            end
                        end
                        addr_q      <= next_addr;
                        remaining_q <= next_rem;
                        if (next_rem == 32'd0 || abort_now) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= S_FIN;
                        end else begin
                            len_q         <= next_len;
                            M_AXI.awaddr  <= next_addr;
                            M_AXI.awlen   <= 8'(next_len - 9'd1);
                            M_AXI.awvalid <= 1'b1;
                            state         <= S_AW;
                        end
                    end
                end

                S_FIN: begin
                    // Arriving from B, DONE is already high and this cycle
                    // ends the pulse. Arriving straight from IDLE (zero-length
                    // request), DONE is raised here and FIN lasts two cycles.
                    if (DONE) begin
                        DONE  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        DONE <= 1'b1;
                        BUSY <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
